// File: rtl/stroke_scheduler.sv
// stroke_scheduler: walks one brush layer on an R x R grid and queries the error
// unit for each cell. When a cell's error exceeds the threshold, it launches one
// stroke at the cell's worst pixel and waits for the stroke engine to finish.
//
// Latency and backpressure:
//   - start to first o_err_req: 1 cycle
//   - a cell without a stroke takes ERR + NEXT cycles
//   - a cell with a stroke takes ERR + STK + WAIT + NEXT cycles
//   - the query is held until i_err_valid; WAIT holds until i_stk_done
//
// Ports:
//   i_clk, i_rst                          clock, async active-high reset
//   i_start, i_radius, i_thresh           layer start, radius R (0 -> 1), threshold
//   o_busy, o_done                        layer in progress / one-cycle completion
//   o_err_req, o_err_x/y/w/h              error query for the current cell
//   i_err_valid, i_err_val, i_err_px/py   error result and worst-pixel location
//   o_stk_start, o_stk_x0/y0, o_stk_r     stroke launch and its parameters
//   i_stk_done                            stroke engine finish pulse
//   o_stroke_cnt                          strokes launched this layer (saturating)
//   o_timeout_cnt                         abandoned strokes (only with SCHED_TIMEOUT_EN)
//
// Optional feature: define SCHED_TIMEOUT_EN to enable the stroke-wait watchdog.
// The watchdog abandons WAIT after TIMEOUT cycles and counts each abandonment.
module stroke_scheduler #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_radius,
  input  logic [15:0] i_thresh,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err_req,
  output logic [9:0]  o_err_x,
  output logic [9:0]  o_err_y,
  output logic [3:0]  o_err_w,
  output logic [3:0]  o_err_h,
  input  logic        i_err_valid,
  input  logic [15:0] i_err_val,
  input  logic [9:0]  i_err_px,
  input  logic [9:0]  i_err_py,
  output logic        o_stk_start,
  output logic [9:0]  o_stk_x0,
  output logic [9:0]  o_stk_y0,
  output logic [3:0]  o_stk_r,
  input  logic        i_stk_done,
  output logic [15:0] o_stroke_cnt
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic [7:0]  o_timeout_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_STK,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Canvas dimensions are kept in 11 bits so that x + R never wraps.
  localparam logic [10:0] W11 = 11'(IMG_W);
  localparam logic [10:0] H11 = 11'(IMG_H);

  state_t      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [15:0] thresh_q, thresh_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [9:0]  stk_x_q, stk_x_d;
  logic [9:0]  stk_y_q, stk_y_d;
  logic [15:0] cnt_q, cnt_d;

`ifdef SCHED_TIMEOUT_EN
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]     tocnt_q, tocnt_d;
`endif

  logic [10:0] r11;
  logic [10:0] x_step;
  logic [10:0] y_step;
  logic [10:0] rem_w;
  logic [10:0] rem_h;

  assign r11    = {7'd0, r_q};
  assign x_step = x_q + r11;
  assign y_step = y_q + r11;
  assign rem_w  = W11 - x_q;
  assign rem_h  = H11 - y_q;

  // Clip the cell at the right and bottom canvas edges. When the remainder is
  // smaller than R, the remainder fits in 4 bits.
  assign o_err_w = (r11 <= rem_w) ? r_q : rem_w[3:0];
  assign o_err_h = (r11 <= rem_h) ? r_q : rem_h[3:0];
  assign o_err_x = x_q[9:0];
  assign o_err_y = y_q[9:0];

  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = (state_q == S_DONE);
  assign o_err_req    = (state_q == S_ERR);
  assign o_stk_start  = (state_q == S_STK);
  assign o_stk_x0     = stk_x_q;
  assign o_stk_y0     = stk_y_q;
  assign o_stk_r      = r_q;
  assign o_stroke_cnt = cnt_q;
`ifdef SCHED_TIMEOUT_EN
  assign o_timeout_cnt = tocnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    thresh_d = thresh_q;
    x_d      = x_q;
    y_d      = y_q;
    stk_x_d  = stk_x_q;
    stk_y_d  = stk_y_q;
    cnt_d    = cnt_q;
`ifdef SCHED_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    tocnt_d  = tocnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          r_d      = (i_radius == 4'd0) ? 4'd1 : i_radius;
          thresh_d = i_thresh;
          x_d      = 11'd0;
          y_d      = 11'd0;
          cnt_d    = 16'd0;
`ifdef SCHED_TIMEOUT_EN
          tocnt_d  = 8'd0;
`endif
          state_d  = S_ERR;
        end
      end
      S_ERR: begin
        if (i_err_valid) begin
          if (i_err_val > thresh_q) begin
            // Load the launch point now so it is already valid in the STK cycle.
            stk_x_d = i_err_px;
            stk_y_d = i_err_py;
            state_d = S_STK;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_STK: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef SCHED_TIMEOUT_EN
        wcnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_stk_done) begin
          state_d = S_NEXT;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (wcnt_q == WLAST) begin
          if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
          state_d = S_NEXT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      S_NEXT: begin
        if (x_step >= W11) begin
          if (y_step >= H11) begin
            state_d = S_DONE;
          end else begin
            x_d     = 11'd0;
            y_d     = y_step;
            state_d = S_ERR;
          end
        end else begin
          x_d     = x_step;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      r_q      <= 4'd0;
      thresh_q <= 16'd0;
      x_q      <= 11'd0;
      y_q      <= 11'd0;
      stk_x_q  <= 10'd0;
      stk_y_q  <= 10'd0;
      cnt_q    <= 16'd0;
`ifdef SCHED_TIMEOUT_EN
      wcnt_q   <= '0;
      tocnt_q  <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      thresh_q <= thresh_d;
      x_q      <= x_d;
      y_q      <= y_d;
      stk_x_q  <= stk_x_d;
      stk_y_q  <= stk_y_d;
      cnt_q    <= cnt_d;
`ifdef SCHED_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      tocnt_q  <= tocnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_stroke_scheduler.sv
// Directed bench for stroke_scheduler. It checks the reset state, stroke and
// no-stroke layers, edge clipping, radius 0, ignored inputs, reset in the middle
// of a layer, and the optional watchdog.
module tb_stroke_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  radius = 4'd0;
  logic [15:0] thresh = 16'd0;
  logic        err_valid = 1'b0;
  logic [15:0] err_val = 16'd0;
  logic [9:0]  err_px = 10'd0;
  logic [9:0]  err_py = 10'd0;
  logic        stk_done = 1'b0;

  logic        busy, done, err_req, stk_start;
  logic [9:0]  err_x, err_y, stk_x0, stk_y0;
  logic [3:0]  err_w, err_h, stk_r;
  logic [15:0] stroke_cnt;
`ifdef SCHED_TIMEOUT_EN
  logic [7:0]  timeout_cnt;
`endif

  // Second instance on a 10x8 canvas for the edge-clipping check.
  logic        start10 = 1'b0;
  logic        busy10, done10, req10, stk_start10;
  logic [9:0]  x10, y10, sx10, sy10;
  logic [3:0]  w10, h10, r10;
  logic [15:0] cnt10;
  logic [15:0] zero16;
  logic [9:0]  zero10;
  logic        zero1;
`ifdef SCHED_TIMEOUT_EN
  logic [7:0]  timeout10;
`endif
  assign zero16 = 16'd0;
  assign zero10 = 10'd0;
  assign zero1  = 1'b0;

  int checks = 0;
  int errors = 0;

  int cx[$], cy[$], cw[$], sx[$], sy[$];

  always #5 clk = ~clk;

  stroke_scheduler #(.IMG_W(16), .IMG_H(8), .TIMEOUT(8)) u_dut (
`ifdef SCHED_TIMEOUT_EN
    .o_timeout_cnt(timeout_cnt),
`endif
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_radius(radius), .i_thresh(thresh),
    .o_busy(busy), .o_done(done), .o_err_req(err_req),
    .o_err_x(err_x), .o_err_y(err_y), .o_err_w(err_w), .o_err_h(err_h),
    .i_err_valid(err_valid), .i_err_val(err_val), .i_err_px(err_px), .i_err_py(err_py),
    .o_stk_start(stk_start), .o_stk_x0(stk_x0), .o_stk_y0(stk_y0), .o_stk_r(stk_r),
    .i_stk_done(stk_done), .o_stroke_cnt(stroke_cnt)
  );

  stroke_scheduler #(.IMG_W(10), .IMG_H(8), .TIMEOUT(8)) u_dut10 (
`ifdef SCHED_TIMEOUT_EN
    .o_timeout_cnt(timeout10),
`endif
    .i_clk(clk), .i_rst(rst), .i_start(start10), .i_radius(radius), .i_thresh(thresh),
    .o_busy(busy10), .o_done(done10), .o_err_req(req10),
    .o_err_x(x10), .o_err_y(y10), .o_err_w(w10), .o_err_h(h10),
    .i_err_valid(req10), .i_err_val(zero16), .i_err_px(zero10), .i_err_py(zero10),
    .o_stk_start(stk_start10), .o_stk_x0(sx10), .o_stk_y0(sy10), .o_stk_r(r10),
    .i_stk_done(zero1), .o_stroke_cnt(cnt10)
  );

  // Runs one layer on u_dut and answers every query immediately. Strokes finish
  // stk_lat cycles after launch; stk_lat = 0 means they never finish. When inj is
  // set, the task pulses start (with another radius) during WAIT and pulses
  // stk_done during every ERR cycle.
  task automatic run_layer(input logic [3:0] rad, input logic [15:0] ev, input int stk_lat,
                           input bit inj, output int cyc_done, output int n_done);
    int cd;
    bit inj_done;
    cx.delete(); cy.delete(); cw.delete(); sx.delete(); sy.delete();
    cd = 0; n_done = 0; cyc_done = -1; inj_done = 0;
    radius = rad; thresh = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4000; i++) begin
      start = 1'b0; radius = rad; stk_done = 1'b0; err_valid = 1'b0;
      if (done) begin
        n_done++;
        if (cyc_done < 0) cyc_done = i;
      end
      if (!busy && cyc_done >= 0) break;
      if (cd > 0) begin
        cd--;
        if (cd == 0) stk_done = 1'b1;
        if (inj && !inj_done) begin
          start = 1'b1; radius = 4'd2; inj_done = 1;
        end
      end
      if (stk_start) begin
        sx.push_back(int'(stk_x0)); sy.push_back(int'(stk_y0));
        cd = stk_lat;
      end
      if (err_req) begin
        cx.push_back(int'(err_x)); cy.push_back(int'(err_y)); cw.push_back(int'(err_w));
        err_valid = 1'b1; err_val = ev;
        err_px = err_x + 10'd1; err_py = err_y + 10'd2;
        if (inj) stk_done = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; err_valid = 1'b0; stk_done = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err_req, stk_start} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, err_req, stk_start});
    end
    checks++;
    if ({stroke_cnt, stk_x0, stk_y0, stk_r, err_x, err_y} !== '0) begin
      errors++; $display("FAIL reset_data cnt=%0d x0=%0d y0=%0d r=%0d want all 0", stroke_cnt, stk_x0, stk_y0, stk_r);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_strokes();
    int cyc, nd;
    run_layer(4'd4, 16'd200, 3, 0, cyc, nd);
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL strokes_done got %0d want 1", nd); end
    checks++;
    if (cx.size() !== 8 || sx.size() !== 8) begin
      errors++; $display("FAIL strokes_count cells=%0d strokes=%0d want 8/8", cx.size(), sx.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (cx[k] !== (k % 4) * 4 || cy[k] !== (k / 4) * 4 || cw[k] !== 4 ||
            sx[k] !== (k % 4) * 4 + 1 || sy[k] !== (k / 4) * 4 + 2) begin
          errors++;
          $display("FAIL strokes_cell%0d got (%0d,%0d) w=%0d stk=(%0d,%0d) want (%0d,%0d) w=4 stk=(%0d,%0d)",
                   k, cx[k], cy[k], cw[k], sx[k], sy[k], (k % 4) * 4, (k / 4) * 4, (k % 4) * 4 + 1, (k / 4) * 4 + 2);
        end
      end
    end
    checks++;
    if (stroke_cnt !== 16'd8) begin errors++; $display("FAIL strokes_cnt got %0d want 8", stroke_cnt); end
    checks++;
    if (stk_r !== 4'd4) begin errors++; $display("FAIL strokes_r got %0d want 4", stk_r); end
  endtask

  task automatic test_no_stroke();
    int cyc, nd;
    run_layer(4'd4, 16'd100, 3, 0, cyc, nd);
    checks++;
    if (sx.size() !== 0 || cx.size() !== 8) begin
      errors++; $display("FAIL nostroke_count strokes=%0d cells=%0d want 0/8", sx.size(), cx.size());
    end
    checks++;
    if (stroke_cnt !== 16'd0) begin errors++; $display("FAIL nostroke_cnt got %0d want 0", stroke_cnt); end
    checks++;
    if (cyc !== 16 || nd !== 1) begin errors++; $display("FAIL nostroke_latency got %0d (dones %0d) want 16 (1)", cyc, nd); end
  endtask

  task automatic test_edge_width();
    int xs[$], ws[$];
    bit seen_done;
    seen_done = 0;
    radius = 4'd4; thresh = 16'd100; start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req10) begin xs.push_back(int'(x10)); ws.push_back(int'(w10)); end
      if (done10) begin seen_done = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen_done || xs.size() !== 6) begin
      errors++; $display("FAIL edge_cells got %0d done=%0d want 6 done=1", xs.size(), seen_done);
    end else begin
      checks++;
      if (xs[2] !== 8 || ws[2] !== 2 || ws[0] !== 4 || ws[5] !== 2) begin
        errors++; $display("FAIL edge_width got x=%0d w=%0d w0=%0d w5=%0d want x=8 w=2 w0=4 w5=2", xs[2], ws[2], ws[0], ws[5]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_radius_zero();
    int cyc, nd;
    run_layer(4'd0, 16'd0, 3, 0, cyc, nd);
    checks++;
    if (stk_r !== 4'd1) begin errors++; $display("FAIL r0_radius got %0d want 1", stk_r); end
    checks++;
    if (cx.size() !== 128 || nd !== 1) begin
      errors++; $display("FAIL r0_cells got %0d (dones %0d) want 128 (1)", cx.size(), nd);
    end else begin
      checks++;
      if (cx[127] !== 15 || cy[127] !== 7 || cw[0] !== 1 || cx[17] !== 1 || cy[17] !== 1) begin
        errors++; $display("FAIL r0_order last=(%0d,%0d) c17=(%0d,%0d) w=%0d want (15,7) (1,1) w=1",
                           cx[127], cy[127], cx[17], cy[17], cw[0]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    int cyc, nd;
    bit ok;
    run_layer(4'd4, 16'd200, 2, 1, cyc, nd);
    ok = (cx.size() == 8) && (sx.size() == 8);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        if (cx[k] != (k % 4) * 4 || cy[k] != (k / 4) * 4) ok = 0;
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ignored_seq cells=%0d strokes=%0d want 8/8 raster", cx.size(), sx.size()); end
    checks++;
    if (stroke_cnt !== 16'd8 || stk_r !== 4'd4 || nd !== 1) begin
      errors++; $display("FAIL ignored_state cnt=%0d r=%0d dones=%0d want 8 4 1", stroke_cnt, stk_r, nd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nd;
    bit bad;
    radius = 4'd4; thresh = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; err_valid = 1'b1; err_val = 16'd200; err_px = 10'd5; err_py = 10'd6;
    @(posedge clk); #1;
    err_valid = 1'b0;
    checks++;
    if (stk_start !== 1'b1 || stk_x0 !== 10'd5 || stk_y0 !== 10'd6) begin
      errors++; $display("FAIL mid_launch got start=%b x0=%0d y0=%0d want 1 5 6", stk_start, stk_x0, stk_y0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err_req, stk_start, stroke_cnt, stk_x0, stk_y0, stk_r, err_x, err_y, err_w} !== '0) begin
      errors++; $display("FAIL mid_reset busy=%b cnt=%0d x0=%0d r=%0d w=%0d want all 0", busy, stroke_cnt, stk_x0, stk_r, err_w);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_nodone got activity after reset want idle"); end
    run_layer(4'd4, 16'd200, 1, 0, cyc, nd);
    checks++;
    if (cx.size() < 1 || cx[0] !== 0 || cy[0] !== 0 || stroke_cnt !== 16'd8 || nd !== 1) begin
      errors++; $display("FAIL mid_restart cells=%0d cnt=%0d dones=%0d want first (0,0) cnt=8 dones=1", cx.size(), stroke_cnt, nd);
    end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, nd;
    run_layer(4'd8, 16'd200, 0, 0, cyc, nd);
    checks++;
    if (timeout_cnt !== 8'd2 || sx.size() !== 2 || stroke_cnt !== 16'd2 || nd !== 1) begin
      errors++; $display("FAIL timeout got tcnt=%0d strokes=%0d cnt=%0d dones=%0d want 2 2 2 1",
                         timeout_cnt, sx.size(), stroke_cnt, nd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_strokes();
    test_no_stroke();
    test_edge_width();
    test_radius_zero();
    test_ignored_inputs();
    test_reset_mid();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stroke_scheduler.md
# stroke_scheduler

Sequences the painterly stroke engine over one brush layer. For a given radius R it walks the canvas on an R×R grid, queries the error unit for each cell's summed error and worst pixel, and, when the error exceeds a threshold, launches one stroke at the worst pixel. It waits for the stroke engine to finish before moving to the next cell. It sits between the layer-level control (one start per brush size) and the stroke engine / error-compute units.

## Interface
Parameters:
- IMG_W, 640, canvas width in pixels (≤1023)
- IMG_H, 480, canvas height in pixels (≤1023)
- TIMEOUT, 1024, stroke-wait watchdog limit in cycles (used only with SCHED_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle layer start; accepted only in IDLE
- i_radius  in  4  brush radius R; latched at start; 0 is treated as 1
- i_thresh  in  16  error threshold; latched at start
- o_busy  out  1  high from accepted start until the o_done cycle, inclusive
- o_done  out  1  one-cycle pulse after the last cell
- o_err_req  out  1  error query request; held until i_err_valid
- o_err_x, o_err_y  out  10 each  cell origin
- o_err_w, o_err_h  out  4 each  cell size, clipped at the canvas edge
- i_err_valid  in  1  error result valid; sampled only while o_err_req=1
- i_err_val  in  16  cell error sum
- i_err_px, i_err_py  in  10 each  worst-pixel coordinates
- o_stk_start  out  1  one-cycle stroke launch
- o_stk_x0, o_stk_y0  out  10 each  stroke start point, stable from launch until the next launch
- o_stk_r  out  4  latched radius
- i_stk_done  in  1  stroke engine finish pulse
- o_stroke_cnt  out  16  strokes launched this layer, saturating at 0xFFFF

## Operation
- States: IDLE, ERR, STK, WAIT, NEXT, DONE.
- IDLE + i_start: latch R (0→1) and threshold, set cell=(0,0), clear o_stroke_cnt, go to ERR.
- ERR: o_err_req=1 with stable cell fields. On i_err_valid, go to STK if i_err_val > thresh (strict), else go to NEXT.
- STK: o_stk_start=1 for exactly one cycle. o_stk_x0/y0 take the captured i_err_px/py. o_stroke_cnt increments (saturating). Go to WAIT.
- WAIT: stay until i_stk_done, then go to NEXT.
- NEXT: x += R. If x ≥ IMG_W, set x=0 and y += R. If y ≥ IMG_H, go to DONE; otherwise go to ERR.
- Cell size: w = min(R, IMG_W−x), h = min(R, IMG_H−y). Use 11-bit internal sums so coordinates never wrap.
- DONE: o_done=1 for one cycle, then IDLE.
- i_start outside IDLE is ignored. i_stk_done outside WAIT is ignored. i_err_valid while o_err_req=0 is ignored.

## Timing
- Reset (async, immediate): state IDLE; all outputs 0, including o_stroke_cnt, coordinates and o_stk_r.
- Reset mid-layer aborts the layer. No o_done is produced; the next layer needs a fresh i_start.
- Start to first o_err_req: 1 cycle.
- Cell with no stroke: ERR (≥1 cycle) + NEXT (1 cycle).
- Stroke cell: ERR + STK (1) + WAIT (≥1) + NEXT (1).
- i_err_valid may arrive in the first ERR cycle.
- i_stk_done is sampled from the cycle after o_stk_start onward. A done in the same cycle as o_stk_start is lost.
- Last cell's NEXT to o_done: 1 cycle. o_busy falls the cycle after o_done.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - WAIT counts cycles. If TIMEOUT cycles elapse without i_stk_done, the scheduler proceeds to NEXT.
  - The stroke stays counted in o_stroke_cnt.
  - Adds output o_timeout_cnt (8 bits, saturating), cleared at start and at reset.
- SCHED_TIMEOUT_EN undefined: WAIT waits indefinitely; no counter and no extra port.

## Test plan
- IMG_W=16, IMG_H=8, R=4, threshold 100, every i_err_val=200 → 8 strokes, visiting origins (0,0),(4,0),…,(12,4) in raster order. o_stroke_cnt=8, one o_done.
- Same setup with all i_err_val=100 → no o_stk_start (strict compare), o_stroke_cnt=0. o_done follows 16 cycles after start, with valid returned immediately.
- IMG_W=10, R=4 → the third column's cell has o_err_w=2. i_radius=0 → o_stk_r=1 and 128 cells on a 16×8 canvas.
- i_start pulsed during WAIT, and i_stk_done pulsed during ERR → both ignored; the cell sequence is unchanged.
- i_rst asserted while in WAIT → all outputs 0 immediately. No o_done. A new start begins at (0,0) with o_stroke_cnt=0.
- With SCHED_TIMEOUT_EN and TIMEOUT=8, i_stk_done never asserted on a 2-cell layer → each stroke abandons after 8 cycles; o_timeout_cnt=2, o_done asserted.
